// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: state encoding, increment and defaults.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEF_RESET_PC     = 32'h0000_0000;
  localparam int          DEF_FLUSH_CYCLES = 2;
  // Wide enough for FLUSH_CYCLES-1 with FLUSH_CYCLES up to 7.
  localparam int          CNT_W            = 3;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// 32-bit program counter register: async active-high reset to RESET_PC, load enable.
module pc_reg
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Hold unless load_en; reset wins asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          q <= RESET_PC;
    else if (load_en) q <= d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential advance, stall hold, branch/jump redirect with
// a fixed number of squashed fetch bubbles, halt, and a sticky misalignment flag.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
  parameter int          FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Halt,
  output logic [31:0] PCOut,
  output logic [31:0] PCPlus4,
  output logic        FetchValid,
  output logic        Flush,
  output logic        AlignErr
);

  pc_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              align_err, align_err_nxt;
  logic [31:0]       pc, pc_nxt;
  logic              pc_load;
  logic              redirect;
  logic [31:0]       redir_tgt;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (Clk),
    .rst     (Reset),
    .load_en (pc_load),
    .d       (pc_nxt),
    .q       (pc)
  );

  assign PCOut    = pc;
  // Only combinational output; wraps naturally at 2^32.
  assign PCPlus4  = pc + PC_INC;
  assign AlignErr = align_err;

  // State, bubble counter and sticky alignment flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_RUN;
      cnt       <= '0;
      align_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      align_err <= align_err_nxt;
    end
  end

  // Next state / next PC: branch beats jump beats halt beats stall in RUN.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pc_load       = 1'b0;
    pc_nxt        = pc;
    redirect      = 1'b0;
    redir_tgt     = '0;
    case (state)
      ST_RUN: begin
        if (BranchTaken) begin
          redirect  = 1'b1;
          redir_tgt = BranchTarget;
        end else if (Jump) begin
          redirect  = 1'b1;
          redir_tgt = JumpTarget;
        end else if (Halt) begin
          state_nxt = ST_HALT;
        end else if (!Stall) begin
          pc_load = 1'b1;
          pc_nxt  = PCPlus4;
        end
        // A redirect overrides Stall in the same cycle.
        if (redirect) begin
          pc_load   = 1'b1;
          pc_nxt    = word_align(redir_tgt);
          cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Control requests are dropped while bubbles drain; PC keeps streaming.
        if (!Stall) begin
          pc_load = 1'b1;
          pc_nxt  = PCPlus4;
        end
        if (cnt == '0) state_nxt = ST_RUN;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    align_err_nxt = align_err | (redirect & (|redir_tgt[1:0]));
  end

  // Status outputs decode purely from registered state.
  always_comb begin
    FetchValid = 1'b0;
    Flush      = 1'b0;
    case (state)
      ST_RUN:   FetchValid = 1'b1;
      ST_FLUSH: Flush      = 1'b1;
      default: begin
        FetchValid = 1'b0;
        Flush      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Halt;
  logic [31:0] PCOut;
  logic [31:0] PCPlus4;
  logic        FetchValid;
  logic        Flush;
  logic        AlignErr;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Halt         (Halt),
    .PCOut        (PCOut),
    .PCPlus4      (PCPlus4),
    .FetchValid   (FetchValid),
    .Flush        (Flush),
    .AlignErr     (AlignErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [31:0] pc, input logic fv, input logic fl);
    check({tag, ".pc"}, PCOut, pc);
    check({tag, ".fv"}, {31'd0, FetchValid}, {31'd0, fv});
    check({tag, ".fl"}, {31'd0, Flush}, {31'd0, fl});
  endtask

  task automatic idle();
    Stall = 0; BranchTaken = 0; Jump = 0; Halt = 0;
    BranchTarget = '0; JumpTarget = '0;
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    @(negedge Clk);
    chk_st("rst", 32'h0, 1'b1, 1'b0);
    check("rst.ae", {31'd0, AlignErr}, 32'd0);
    check("rst.pc4", PCPlus4, 32'h4);
    Reset = 1'b0;

    // Sequential fetch after release.
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_st($sformatf("seq%0d", i), 32'(i * 4), 1'b1, 1'b0);
    end
    for (int i = 5; i <= 8; i++) step();
    check("seq.at20", PCOut, 32'h20);

    // Stall alone holds PC with fetch still valid.
    Stall = 1;
    step();
    chk_st("stall", 32'h20, 1'b1, 1'b0);

    // Branch wins over a simultaneous stall, then two bubbles.
    BranchTaken = 1; BranchTarget = 32'h100; Stall = 1;
    step();
    idle();
    chk_st("br.f1", 32'h100, 1'b0, 1'b1);
    step();
    chk_st("br.f2", 32'h104, 1'b0, 1'b1);
    step();
    chk_st("br.run", 32'h108, 1'b1, 1'b0);

    // Branch beats jump; requests during flush are ignored; stall holds PC in flush.
    BranchTaken = 1; BranchTarget = 32'h40; Jump = 1; JumpTarget = 32'h80;
    step();
    idle();
    chk_st("bj.f1", 32'h40, 1'b0, 1'b1);
    Jump = 1; JumpTarget = 32'h80; Stall = 1;
    step();
    chk_st("bj.f2stall", 32'h40, 1'b0, 1'b1);
    Stall = 0; Jump = 1; Halt = 1; BranchTaken = 1; BranchTarget = 32'h300;
    step();
    idle();
    chk_st("bj.run", 32'h44, 1'b1, 1'b0);
    step();
    chk_st("bj.nohalt", 32'h48, 1'b1, 1'b0);

    // Wrap at the top of the address space.
    Jump = 1; JumpTarget = 32'hFFFF_FFF4;
    step();
    idle();
    chk_st("wr.f1", 32'hFFFF_FFF4, 1'b0, 1'b1);
    step();
    step();
    chk_st("wr.run", 32'hFFFF_FFFC, 1'b1, 1'b0);
    check("wr.pc4", PCPlus4, 32'h0);
    step();
    chk_st("wr.wrap", 32'h0, 1'b1, 1'b0);
    check("wr.ae", {31'd0, AlignErr}, 32'd0);

    // Misaligned jump is aligned and flags AlignErr persistently.
    Jump = 1; JumpTarget = 32'h1002;
    step();
    idle();
    chk_st("mis.f1", 32'h1000, 1'b0, 1'b1);
    check("mis.ae1", {31'd0, AlignErr}, 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk_st("mis.run", 32'h100C, 1'b1, 1'b0);
    check("mis.ae2", {31'd0, AlignErr}, 32'd1);
    Reset = 1;
    #1;
    check("mis.rst.ae", {31'd0, AlignErr}, 32'd0);
    chk_st("mis.rst", 32'h0, 1'b1, 1'b0);
    @(negedge Clk);
    Reset = 0;
    step();
    chk_st("rel", 32'h4, 1'b1, 1'b0);

    // Misaligned branch target also sets the flag.
    BranchTaken = 1; BranchTarget = 32'h203;
    step();
    idle();
    chk_st("mbr", 32'h200, 1'b0, 1'b1);
    check("mbr.ae", {31'd0, AlignErr}, 32'd1);

    // Reset in the middle of a flush.
    #2 Reset = 1;
    #1;
    chk_st("rflush", 32'h0, 1'b1, 1'b0);
    check("rflush.ae", {31'd0, AlignErr}, 32'd0);
    @(negedge Clk);
    Reset = 0;
    step();
    chk_st("rflush.rel", 32'h4, 1'b1, 1'b0);

    // Reach 0x30 via a jump, then halt there.
    Jump = 1; JumpTarget = 32'h28;
    step();
    idle();
    step();
    step();
    chk_st("h.pre", 32'h30, 1'b1, 1'b0);
    Halt = 1;
    step();
    chk_st("h.enter", 32'h30, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      Halt = i[0]; Stall = i[1]; BranchTaken = i[2]; Jump = ~i[0];
      BranchTarget = 32'h500; JumpTarget = 32'h601;
      step();
      chk_st($sformatf("h%0d", i), 32'h30, 1'b0, 1'b0);
    end
    check("h.ae", {31'd0, AlignErr}, 32'd0);
    idle();
    #2 Reset = 1;
    #1;
    chk_st("h.rst", 32'h0, 1'b1, 1'b0);
    @(negedge Clk);
    Reset = 0;
    step();
    chk_st("h.rel", 32'h4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1..7, is the number of fetch bubbles issued after a redirect.
REQ-003 Port Clk, input, 1, is the single clock; all state updates occur on its rising edge.
REQ-004 Port Reset, input, 1, is an asynchronous active-high reset.
REQ-005 Port Stall, input, 1, is the hazard-unit hold request.
REQ-006 Port BranchTaken, input, 1, is the resolved-taken branch strobe from the branch-target datapath.
REQ-007 Port BranchTarget, input, 32, is the branch target (PC plus shifted immediate) computed by the datapath adder.
REQ-008 Port Jump, input, 1, is the jump strobe from decode.
REQ-009 Port JumpTarget, input, 32, is the jump destination address.
REQ-010 Port Halt, input, 1, is the halt request.
REQ-011 Port PCOut, output, 32, is the current fetch address.
REQ-012 Port PCPlus4, output, 32, is PCOut+4, combinational, modulo 2^32.
REQ-013 Port FetchValid, output, 1, is high when the instruction fetched at PCOut is valid.
REQ-014 Port Flush, output, 1, is high while pipeline register contents are squashed.
REQ-015 Port AlignErr, output, 1, is a sticky flag set by any misaligned redirect target.

Function
REQ-016 FSM states: RUN, FLUSH, HALT.
REQ-017 In RUN, priority per edge: BranchTaken > Jump > Halt > Stall > sequential.
REQ-018 RUN + BranchTaken: PCOut <= {BranchTarget[31:2],2'b00}; counter <= FLUSH_CYCLES-1; next state FLUSH.
REQ-019 RUN + Jump (no BranchTaken): PCOut <= {JumpTarget[31:2],2'b00}; counter <= FLUSH_CYCLES-1; next state FLUSH.
REQ-020 A redirect is taken even when Stall is high in the same cycle.
REQ-021 RUN + Halt (no redirect): PCOut holds; next state HALT.
REQ-022 RUN + Stall only: PCOut holds; FetchValid stays high; Flush stays low.
REQ-023 RUN with no request: PCOut <= PCPlus4; 32'hFFFF_FFFC wraps to 32'h0000_0000 without error.
REQ-024 FLUSH: Flush=1, FetchValid=0; PCOut advances by 4 unless Stall is high; counter decrements each edge; at counter==0 next state RUN.
REQ-025 FLUSH: BranchTaken, Jump and Halt are ignored.
REQ-026 HALT: PCOut holds, FetchValid=0, Flush=0; all inputs ignored; only Reset exits.
REQ-027 AlignErr sets on the edge a redirect is accepted with target[1:0] != 0 and stays set until Reset.
REQ-028 Outputs other than PCPlus4 are registered or decoded from registered state only; no combinational input-to-output path.

Reset
REQ-029 Reset asserted at any time, including mid-FLUSH or in HALT, immediately forces PCOut=RESET_PC, state RUN, counter 0, FetchValid=1, Flush=0, AlignErr=0.
REQ-030 On the first rising edge after Reset deasserts, normal RUN behaviour applies (PCOut advances to RESET_PC+4 absent requests).

Structure
REQ-031 Package pc_seq_pkg holds the state encoding, PC_INC=4, and the RESET_PC/FLUSH_CYCLES defaults.
REQ-032 One sub-module, pc_reg: 32-bit register with asynchronous active-high reset to RESET_PC and a load enable.

Verification
REQ-033 Reset, release, 4 idle cycles -> PCOut 0,4,8,12,16; FetchValid=1; Flush=0.
REQ-034 At PC=0x20, BranchTaken=1 with BranchTarget=0x100 and Stall=1 -> PCOut=0x100 next edge; Flush=1 for 2 cycles; then PCOut=0x108, FetchValid=1.
REQ-035 BranchTaken and Jump together (BranchTarget=0x40, JumpTarget=0x80) -> PCOut=0x40; Jump pulse during the following FLUSH -> no effect.
REQ-036 PC=0xFFFFFFFC, no requests -> PCOut=0x0, AlignErr=0; Jump to 0x1002 -> PCOut=0x1000, AlignErr=1 until Reset.
REQ-037 Halt at PC=0x30 -> PCOut holds 0x30 for 10 cycles, FetchValid=0; Reset asserted mid-cycle -> PCOut=RESET_PC before the next edge.
